// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter slice.
// Default widths, the NOP opcode and the arbiter FSM state encoding.
package alu_pkg;

  localparam int W_DEF   = 8;
  localparam int OPW_DEF = 4;

  localparam logic [3:0] OP_NOP = 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// On a tie the requester not granted last time wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  assign gnt_idx = gnt[1];

endmodule

// File: rtl/alu_arbiter.sv
// Shares one clocked ALU between two requesters.
// Round-robin accept, hold operands for the ALU latency, return result.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int OPW     = OPW_DEF,
  parameter int ALU_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*W-1:0] req_in1,
  input  logic [2*W-1:0] req_in2,
  input  logic [2*OPW-1:0] req_op,
  output logic [1:0]     resp_valid,
  input  logic [1:0]     resp_ready,
  output logic [W-1:0]   resp_data,
  output logic [W-1:0]   alu_in1,
  output logic [W-1:0]   alu_in2,
  output logic [OPW-1:0] alu_op,
  input  logic [W-1:0]   alu_out,
  output logic           busy
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t         state;
  state_t         nxt;
  logic           last_grant;
  logic           gidx_q;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [OPW-1:0] op_q;
  logic [1:0]     gnt;
  logic           gnt_idx;
  logic           accept;
  logic           hold;

  rr_arb2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  assign accept = (state == IDLE) && (|req_valid);
  assign hold   = (state == EXEC) || (state == CAPT);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (accept) nxt = EXEC;
      EXEC: if (cnt == '0) nxt = CAPT;
      CAPT: nxt = RESP;
      RESP: if (resp_ready[gidx_q]) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
      gidx_q     <= 1'b0;
      cnt        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      resp_data  <= '0;
    end else begin
      if (accept) begin
        a_q        <= req_in1[gnt_idx*W +: W];
        b_q        <= req_in2[gnt_idx*W +: W];
        op_q       <= req_op[gnt_idx*OPW +: OPW];
        last_grant <= gnt_idx;
        gidx_q     <= gnt_idx;
        cnt        <= CW'(ALU_LAT - 1);
      end else if (state == EXEC && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (state == CAPT) resp_data <= alu_out;
    end
  end

  // ALU inputs follow state so an async reset zeroes them at once
  assign alu_in1 = hold ? a_q : '0;
  assign alu_in2 = hold ? b_q : '0;
  assign alu_op  = hold ? op_q : OPW'(OP_NOP);

  assign req_ready  = (state == IDLE && rst) ? gnt : 2'b00;
  assign resp_valid = (state == RESP) ? (gidx_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with clocked ALU stubs.
// Covers single op, ties, backpressure, ALU_LAT=3, reset abort, withdrawal.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [15:0] req_in1, req_in2;
  logic [7:0]  req_op;
  logic [7:0]  resp_data, alu_in1, alu_in2, alu_out;
  logic [3:0]  alu_op;
  logic        busy;

  logic [1:0]  t_req_valid, t_req_ready, t_resp_valid, t_resp_ready;
  logic [15:0] t_req_in1, t_req_in2;
  logic [7:0]  t_req_op;
  logic [7:0]  t_resp_data, t_alu_in1, t_alu_in2, t_alu_out;
  logic [3:0]  t_alu_op;
  logic        t_busy;
  logic [7:0]  s1, s2;

  int total = 0;
  int bad   = 0;
  int seen;

  always #5 clk = ~clk;

  alu_arbiter #(.W(8), .OPW(4), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_out(alu_out), .busy(busy)
  );

  alu_arbiter #(.W(8), .OPW(4), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(t_req_valid), .req_ready(t_req_ready),
    .req_in1(t_req_in1), .req_in2(t_req_in2), .req_op(t_req_op),
    .resp_valid(t_resp_valid), .resp_ready(t_resp_ready),
    .resp_data(t_resp_data),
    .alu_in1(t_alu_in1), .alu_in2(t_alu_in2), .alu_op(t_alu_op),
    .alu_out(t_alu_out), .busy(t_busy)
  );

  function automatic logic [7:0] f(input logic [7:0] a,
                                   input logic [7:0] b,
                                   input logic [3:0] op);
    case (op)
      4'd1:    return a + b;
      4'd2:    return a - b;
      default: return 8'd0;
    endcase
  endfunction

  always_ff @(posedge clk) alu_out <= f(alu_in1, alu_in2, alu_op);

  always_ff @(posedge clk) begin
    s1        <= f(t_alu_in1, t_alu_in2, t_alu_op);
    s2        <= s1;
    t_alu_out <= s2;
  end

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic setr(input int i, input logic [7:0] a,
                      input logic [7:0] b, input logic [3:0] op);
    req_in1[i*8 +: 8] = a;
    req_in2[i*8 +: 8] = b;
    req_op[i*4 +: 4]  = op;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 2'b00; resp_ready = 2'b00;
    req_in1 = '0; req_in2 = '0; req_op = '0;
    t_req_valid = 2'b00; t_resp_ready = 2'b11;
    t_req_in1 = '0; t_req_in2 = '0; t_req_op = '0;
    #12;
    req_valid = 2'b01;
    #1;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rvalid", resp_valid, 2'b00);
    chk("rst_rdata", resp_data, 8'd0);
    chk("rst_in1", alu_in1, 8'd0);
    chk("rst_in2", alu_in2, 8'd0);
    chk("rst_op", alu_op, 4'd0);
    req_valid = 2'b00;
    nxt();
    rst = 1'b1;

    // single request from requester 0
    nxt();
    setr(0, 8'd25, 8'd18, 4'd1);
    req_valid = 2'b01;
    #1 chk("s_ready", req_ready, 2'b01);
    nxt();
    req_valid = 2'b00;
    #1;
    chk("s_busy", busy, 1'b1);
    chk("s_c1_in1", alu_in1, 8'd25);
    chk("s_c1_in2", alu_in2, 8'd18);
    chk("s_c1_op", alu_op, 4'd1);
    chk("s_c1_rv", resp_valid, 2'b00);
    nxt();
    #1;
    chk("s_c2_in1", alu_in1, 8'd25);
    chk("s_c2_op", alu_op, 4'd1);
    chk("s_c2_rv", resp_valid, 2'b00);
    nxt();
    resp_ready = 2'b01;
    #1;
    chk("s_c3_rv", resp_valid, 2'b01);
    chk("s_c3_data", resp_data, 8'd43);
    nxt();
    #1;
    chk("s_idle_busy", busy, 1'b0);
    chk("s_idle_in1", alu_in1, 8'd0);
    chk("s_idle_rv", resp_valid, 2'b00);

    // tie at reset release
    rst = 1'b0;
    #1;
    setr(0, 8'd25, 8'd18, 4'd2);
    setr(1, 8'd9, 8'd4, 4'd1);
    req_valid = 2'b11;
    resp_ready = 2'b11;
    nxt();
    rst = 1'b1;
    #1 chk("tie_first", req_ready, 2'b01);
    nxt();
    req_valid = 2'b10;
    nxt();
    nxt();
    #1;
    chk("tie_r0_rv", resp_valid, 2'b01);
    chk("tie_r0_data", resp_data, 8'd7);
    nxt();
    #1 chk("tie_second", req_ready, 2'b10);
    nxt();
    req_valid = 2'b00;
    nxt();
    nxt();
    #1;
    chk("tie_r1_rv", resp_valid, 2'b10);
    chk("tie_r1_data", resp_data, 8'd13);
    nxt();
    resp_ready = 2'b00;
    setr(0, 8'd100, 8'd30, 4'd1);
    req_valid = 2'b11;
    #1 chk("tie_again", req_ready, 2'b01);

    // backpressure while requester 1 keeps asking
    nxt();
    req_valid = 2'b10;
    #1 chk("bp_exec_ready", req_ready, 2'b00);
    nxt();
    nxt();
    for (int i = 0; i < 5; i++) begin
      resp_ready = (i == 2) ? 2'b10 : 2'b00;
      #1;
      chk("bp_rv", resp_valid, 2'b01);
      chk("bp_data", resp_data, 8'd130);
      chk("bp_ready", req_ready, 2'b00);
      nxt();
    end
    resp_ready = 2'b01;
    #1 chk("bp_rv_end", resp_valid, 2'b01);
    nxt();
    #1 chk("bp_next_ready", req_ready, 2'b10);

    // withdrawn pulse while busy
    nxt();
    req_valid = 2'b10;
    resp_ready = 2'b11;
    #1;
    chk("wd_busy", busy, 1'b1);
    chk("wd_ready", req_ready, 2'b00);
    nxt();
    req_valid = 2'b00;
    nxt();
    #1;
    chk("wd_rv", resp_valid, 2'b10);
    chk("wd_data", resp_data, 8'd13);
    nxt();
    #1;
    chk("wd_idle_ready", req_ready, 2'b00);
    nxt();
    #1 chk("wd_no_txn", busy, 1'b0);

    // reset pulse during EXEC
    setr(0, 8'd50, 8'd5, 4'd1);
    req_valid = 2'b01;
    #1 chk("ra_ready", req_ready, 2'b01);
    nxt();
    req_valid = 2'b00;
    #1 chk("ra_exec_in1", alu_in1, 8'd50);
    #1 rst = 1'b0;
    #1;
    chk("ra_in1", alu_in1, 8'd0);
    chk("ra_in2", alu_in2, 8'd0);
    chk("ra_op", alu_op, 4'd0);
    chk("ra_busy", busy, 1'b0);
    chk("ra_rv", resp_valid, 2'b00);
    chk("ra_data", resp_data, 8'd0);
    nxt();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      #1 if (resp_valid != 2'b00) seen++;
      nxt();
    end
    chk("ra_no_resp", seen, 0);
    setr(0, 8'd200, 8'd55, 4'd2);
    req_valid = 2'b01;
    #1 chk("ra_next_ready", req_ready, 2'b01);
    nxt();
    req_valid = 2'b00;
    nxt();
    nxt();
    #1;
    chk("ra_next_rv", resp_valid, 2'b01);
    chk("ra_next_data", resp_data, 8'd145);

    // ALU_LAT = 3 instance
    nxt();
    t_req_in1[15:8] = 8'd7;
    t_req_in2[15:8] = 8'd3;
    t_req_op[7:4]   = 4'd1;
    t_req_valid = 2'b10;
    #1 chk("l3_ready", t_req_ready, 2'b10);
    for (int i = 1; i <= 4; i++) begin
      nxt();
      t_req_valid = 2'b00;
      #1;
      chk("l3_in1", t_alu_in1, 8'd7);
      chk("l3_op", t_alu_op, 4'd1);
      chk("l3_rv_early", t_resp_valid, 2'b00);
    end
    nxt();
    #1;
    chk("l3_rv", t_resp_valid, 2'b10);
    chk("l3_data", t_resp_data, 8'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
